mem_port_arbiter: RTL

//  Shares one single-port word SRAM between the core's instruction-fetch port and its data port.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, port ids, latency counter.
// Also holds the data-port address fault rule so every user applies the same one.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // Wide enough to count the longest legal read latency (4).
  localparam int LAT_CNT_W = 3;

  // Misaligned, or beyond the byte space backed by an addr_w-bit word address.
  function automatic logic dm_addr_fault(input logic [31:0] addr, input int unsigned addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a single request wins outright, a tie goes to the port not granted last.
// Grant is combinational from the requests; last_gnt advances only on cycles where upd is high.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_dm,
  input  logic upd,
  output logic gnt_vld,
  output logic gnt_port
);

  logic last_gnt;

  always_comb begin
    gnt_vld = req_if | req_dm;
    if (req_if && req_dm) begin
      gnt_port = ~last_gnt;
    end else begin
      gnt_port = req_dm ? PORT_DM : PORT_IF;
    end
  end

  // Reset to DM so the first tie after reset goes to instruction fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= PORT_DM;
    end else if (upd && gnt_vld) begin
      last_gnt <= gnt_port;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word SRAM between fetch and data ports; one access in flight at a time.
// Read done at T+2+MEM_LAT, write at T+2, data fault at T+1; requests are only sampled in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic [31:0]       dm_addr,
  input  logic [3:0]        dm_we,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  logic [1:0]           state;
  logic                 cur_port;
  logic                 cur_err;
  logic [ADDR_W-1:0]    cur_addr;
  logic [3:0]           cur_we;
  logic [31:0]          cur_wdata;
  logic [LAT_CNT_W-1:0] lat_cnt;

  logic idle;
  logic gnt_vld;
  logic gnt_port;
  logic dm_fault;
  logic lat_last;

  // Fetch addresses are word-truncated; the dropped bits are deliberately ignored.
  logic unused_if_bits;
  assign unused_if_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0]};

  assign idle     = (state == ST_IDLE);
  assign dm_fault = dm_addr_fault(dm_addr, ADDR_W);
  assign lat_last = (lat_cnt == LAT_CNT_W'(MEM_LAT - 1));

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_if   (if_req),
    .req_dm   (dm_req),
    .upd      (idle),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_port  <= PORT_IF;
      cur_err   <= 1'b0;
      cur_addr  <= '0;
      cur_we    <= 4'd0;
      cur_wdata <= 32'd0;
      lat_cnt   <= '0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            cur_port <= gnt_port;
            lat_cnt  <= '0;
            if (gnt_port == PORT_IF) begin
              cur_addr  <= if_addr[ADDR_W+1:2];
              cur_we    <= 4'd0;
              cur_wdata <= 32'd0;
              cur_err   <= 1'b0;
              state     <= ST_ISSUE;
            end else begin
              cur_addr  <= dm_addr[ADDR_W+1:2];
              cur_we    <= dm_we;
              cur_wdata <= dm_wdata;
              cur_err   <= dm_fault;
              // A faulted request never touches memory and answers straight away.
              state     <= dm_fault ? ST_RESP : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state <= (cur_we != 4'd0) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_last) begin
            if (cur_port == PORT_IF) begin
              if_rdata <= mem_rdata;
            end else begin
              dm_rdata <= mem_rdata;
            end
            state <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == ST_ISSUE);
    mem_addr  = cur_addr;
    mem_we    = mem_en ? cur_we : 4'd0;
    mem_wdata = mem_en ? cur_wdata : 32'd0;
    if_done   = (state == ST_RESP) && (cur_port == PORT_IF);
    dm_done   = (state == ST_RESP) && (cur_port == PORT_DM);
    dm_err    = dm_done && cur_err;
    busy      = !idle;
  end

  a_done_exclusive: assert property (@(posedge clk) disable iff (rst) !(if_done && dm_done));
  a_err_with_done:  assert property (@(posedge clk) disable iff (rst) (dm_err |-> dm_done));

endmodule
